seq_detect_ctrl: RTL and testbench

- Programmable serial-pattern detector controller: generalises the fixed "11" sequence detector into a runtime-configured engine.
- Accepts a pattern, length, overlap mode and match target over a valid/ready config handshake.
- Started by a pulse; scans a qualified serial bit stream; counts matches; signals done at the target.
- Sits between the system sequencer and the serial input path; one instance per monitored stream.

---
 rtl/seq_pkg.sv | 33 +++
 rtl/seq_match_core.sv | 51 +++++
 rtl/seq_detect_ctrl.sv | 142 ++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and helpers for the programmable serial-pattern detector.
package seq_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;

    // Forces a requested pattern length into the legal range 1..max_len.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        if (len == 0) begin
            return 1;
        end
        if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

    // One bit of the compare mask: bit idx takes part in the compare when idx < len.
    function automatic logic mask_bit(input int unsigned idx,
                                      input int unsigned len);
        return (idx < len);
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// History shift register, fill counter and masked pattern compare.
// The match output looks at the history as it will be after the current bit.
module seq_match_core
    import seq_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_bit,
    input  logic               in_valid,
    input  logic               clear,
    input  logic               overlap,
    input  logic [LEN_W-1:0]   len,
    input  logic [MAX_LEN-1:0] pattern,
    output logic               match
);

    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] hist_d;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_d;

    // Per-bit compare mask derived from the (already sanitised) length
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign mask[gi] = mask_bit(gi, 32'(len));
        end
    endgenerate

    // Next-state history/fill and the match decision on that next state
    always_comb begin
        hist_d = {hist_q[MAX_LEN-2:0], in_bit};
        fill_d = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
        match  = in_valid && (fill_d >= len) && (((hist_d ^ pattern) & mask) == '0);
    end

    // Shift only on qualified bits; non-overlap mode restarts the fill after a hit
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (in_valid) begin
            hist_q <= hist_d;
            fill_q <= (match && !overlap) ? '0 : fill_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detector controller: config handshake,
// run/stop FSM, match counter and done detection around seq_match_core.
module seq_detect_ctrl
    import seq_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               stop,
    input  logic               in,
    input  logic               in_valid,
    output logic               o,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done
);

    state_e             state_q;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [CNT_W-1:0]   target_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               o_q;
    logic               busy_q;
    logic               done_q;
    logic               ready_q;

    logic               cfg_accept;
    logic               start_run;
    logic               run_valid;
    logic               core_match;
    logic               target_hit;

    // Handshake qualification and run-start / run-bit strobes
    always_comb begin
        cfg_accept = cfg_valid && ready_q;
        start_run  = start && !cfg_accept &&
                     ((state_q == ST_ARMED) || (state_q == ST_DONE));
        run_valid  = in_valid && (state_q == ST_RUN);
    end

    // Saturating count increment and target comparison
    always_comb begin
        cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        target_hit = (target_q != '0) &&
                     (({1'b0, cnt_q} + (CNT_W+1)'(1)) == {1'b0, target_q});
    end

    seq_match_core #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_bit   (in),
        .in_valid (run_valid),
        .clear    (start_run),
        .overlap  (overlap_q),
        .len      (len_q),
        .pattern  (pattern_q),
        .match    (core_match)
    );

    // Controller FSM with registered state decodes and match pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            target_q  <= '0;
            cnt_q     <= '0;
            o_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            o_q <= 1'b0;
            if (cfg_accept) begin
                // Config accept outranks stop/start and always lands in ARMED
                pattern_q <= cfg_pattern;
                len_q     <= LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
                overlap_q <= cfg_overlap;
                target_q  <= cfg_target;
                state_q   <= ST_ARMED;
                busy_q    <= 1'b0;
                done_q    <= 1'b0;
                ready_q   <= 1'b1;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (stop) begin
                            state_q <= ST_ARMED;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end else if (core_match) begin
                            o_q   <= 1'b1;
                            cnt_q <= cnt_d;
                            if (target_hit) begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                ready_q <= 1'b1;
                            end
                        end
                    end
                    ST_ARMED, ST_DONE: begin
                        if (start_run) begin
                            state_q <= ST_RUN;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            ready_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o         = o_q;
    assign match_cnt = cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_ready = ready_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl with hand-computed expectations.
module tb_seq_detect_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = $clog2(MAX_LEN) + 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic               start;
    logic               stop;
    logic               in_bit;
    logic               in_valid;
    logic               o;
    logic [CNT_W-1:0]   match_cnt;
    logic               busy;
    logic               done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .stop        (stop),
        .in          (in_bit),
        .in_valid    (in_valid),
        .o           (o),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done)
    );

    // Advance one clock and settle just after the edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic configure(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                             input logic ovl, input logic [CNT_W-1:0] tgt);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_target  = tgt;
        cfg_valid   = 1'b1;
        cycle();
        cfg_valid   = 1'b0;
        $display("cfg pat=%0h len=%0d ovl=%0d tgt=%0d ready=%0d", pat, len, ovl, tgt, cfg_ready);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
        $display("start busy=%0d done=%0d cnt=%0d", busy, done, match_cnt);
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        $display("stop busy=%0d cnt=%0d", busy, match_cnt);
    endtask

    // Present one valid bit and check the registered match pulse
    task automatic send(input string tag, input logic b, input logic exp_o);
        in_bit   = b;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        $display("bit %s in=%0d o=%0d cnt=%0d", tag, b, o, match_cnt);
        check(tag, 32'(o), 32'(exp_o));
    endtask

    task automatic gap(input string tag);
        in_valid = 1'b0;
        in_bit   = 1'b1;
        cycle();
        $display("gap %s o=%0d", tag, o);
        check(tag, 32'(o), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        cfg_valid   = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        cfg_target  = '0;
        start       = 1'b0;
        stop        = 1'b0;
        in_bit      = 1'b0;
        in_valid    = 1'b0;
        cycle();
        cycle();
        check("rst_o", 32'(o), 32'd0);
        check("rst_cnt", 32'(match_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        rst_n = 1'b1;
        cycle();

        // start in IDLE is ignored
        pulse_start();
        check("idle_start_busy", 32'(busy), 32'd0);

        // Case 1: "11", len 2, overlap, no target
        configure(8'b11, 4'd2, 1'b1, 8'd0);
        check("c1_armed_busy", 32'(busy), 32'd0);
        check("c1_armed_ready", 32'(cfg_ready), 32'd1);
        pulse_start();
        check("c1_busy", 32'(busy), 32'd1);
        check("c1_ready", 32'(cfg_ready), 32'd0);
        send("c1_b1", 1'b0, 1'b0);
        send("c1_b2", 1'b1, 1'b0);
        send("c1_b3", 1'b1, 1'b1);
        send("c1_b4", 1'b1, 1'b1);
        send("c1_b5", 1'b0, 1'b0);
        send("c1_b6", 1'b1, 1'b0);
        send("c1_b7", 1'b1, 1'b1);
        check("c1_cnt", 32'(match_cnt), 32'd3);
        check("c1_done", 32'(done), 32'd0);
        pulse_stop();
        check("c1_stop_busy", 32'(busy), 32'd0);
        check("c1_stop_cnt", 32'(match_cnt), 32'd3);

        // Case 2: same stream, non-overlapping
        configure(8'b11, 4'd2, 1'b0, 8'd0);
        pulse_start();
        check("c2_cnt0", 32'(match_cnt), 32'd0);
        send("c2_b1", 1'b0, 1'b0);
        send("c2_b2", 1'b1, 1'b0);
        send("c2_b3", 1'b1, 1'b1);
        send("c2_b4", 1'b1, 1'b0);
        send("c2_b5", 1'b0, 1'b0);
        send("c2_b6", 1'b1, 1'b0);
        send("c2_b7", 1'b1, 1'b1);
        check("c2_cnt", 32'(match_cnt), 32'd2);
        pulse_stop();

        // Case 3: "1011", len 4, overlap, target 2
        configure(8'b1011, 4'd4, 1'b1, 8'd2);
        pulse_start();
        send("c3_b1", 1'b1, 1'b0);
        send("c3_b2", 1'b0, 1'b0);
        send("c3_b3", 1'b1, 1'b0);
        send("c3_b4", 1'b1, 1'b1);
        check("c3_cnt1", 32'(match_cnt), 32'd1);
        check("c3_busy_mid", 32'(busy), 32'd1);
        send("c3_b5", 1'b0, 1'b0);
        send("c3_b6", 1'b1, 1'b0);
        send("c3_b7", 1'b1, 1'b1);
        check("c3_done", 32'(done), 32'd1);
        check("c3_busy", 32'(busy), 32'd0);
        check("c3_ready", 32'(cfg_ready), 32'd1);
        check("c3_cnt2", 32'(match_cnt), 32'd2);
        send("c3_x1", 1'b0, 1'b0);
        send("c3_x2", 1'b1, 1'b0);
        send("c3_x3", 1'b1, 1'b0);
        check("c3_cnt_hold", 32'(match_cnt), 32'd2);
        pulse_start();
        check("c3_restart_busy", 32'(busy), 32'd1);
        check("c3_restart_done", 32'(done), 32'd0);
        check("c3_restart_cnt", 32'(match_cnt), 32'd0);
        pulse_stop();

        // Case 4: case-1 stream with a 3-cycle valid gap after the 2nd bit
        configure(8'b11, 4'd2, 1'b1, 8'd0);
        pulse_start();
        send("c4_b1", 1'b0, 1'b0);
        send("c4_b2", 1'b1, 1'b0);
        gap("c4_g1");
        gap("c4_g2");
        gap("c4_g3");
        send("c4_b3", 1'b1, 1'b1);
        send("c4_b4", 1'b1, 1'b1);
        send("c4_b5", 1'b0, 1'b0);
        send("c4_b6", 1'b1, 1'b0);
        send("c4_b7", 1'b1, 1'b1);
        check("c4_cnt", 32'(match_cnt), 32'd3);

        // Case 5a: cfg_valid offered during RUN is refused
        cfg_pattern = 8'b0;
        cfg_len     = 4'd1;
        cfg_overlap = 1'b0;
        cfg_target  = 8'd1;
        cfg_valid   = 1'b1;
        cycle();
        check("c5_run_ready", 32'(cfg_ready), 32'd0);
        cycle();
        check("c5_run_busy", 32'(busy), 32'd1);
        cfg_valid = 1'b0;
        send("c5_oldcfg", 1'b1, 1'b1);
        check("c5_cnt", 32'(match_cnt), 32'd4);
        check("c5_no_done", 32'(done), 32'd0);
        pulse_stop();

        // Case 5b: config and start together in ARMED; len 0 behaves as len 1
        start = 1'b1;
        configure(8'b1, 4'd0, 1'b1, 8'd0);
        start = 1'b0;
        check("c5_cfgstart_busy", 32'(busy), 32'd0);
        check("c5_cfgstart_ready", 32'(cfg_ready), 32'd1);
        pulse_start();
        send("c5_l1_b1", 1'b1, 1'b1);
        send("c5_l1_b2", 1'b0, 1'b0);
        send("c5_l1_b3", 1'b1, 1'b1);
        check("c5_l1_cnt", 32'(match_cnt), 32'd2);
        pulse_stop();

        // Case 6a: reset mid-run after one of two pattern bits
        configure(8'b11, 4'd2, 1'b1, 8'd0);
        pulse_start();
        send("c6_b1", 1'b1, 1'b0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("c6_rst_o", 32'(o), 32'd0);
        check("c6_rst_cnt", 32'(match_cnt), 32'd0);
        check("c6_rst_busy", 32'(busy), 32'd0);
        check("c6_rst_ready", 32'(cfg_ready), 32'd1);
        pulse_start();
        check("c6_idle_start", 32'(busy), 32'd0);
        configure(8'b11, 4'd2, 1'b1, 8'd0);
        pulse_start();
        send("c6_fresh1", 1'b1, 1'b0);
        send("c6_fresh2", 1'b1, 1'b1);

        // Case 6b: stop in a cycle that would otherwise complete a match
        in_bit   = 1'b1;
        in_valid = 1'b1;
        stop     = 1'b1;
        cycle();
        stop     = 1'b0;
        in_valid = 1'b0;
        $display("stop_with_bit o=%0d busy=%0d cnt=%0d", o, busy, match_cnt);
        check("c6_stop_o", 32'(o), 32'd0);
        check("c6_stop_busy", 32'(busy), 32'd0);
        check("c6_stop_cnt", 32'(match_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
